wb_fft_slave_ctrl: RTL and testbench

//  Wishbone B3 classic slave fronting the FFT core; successor to the fixed-size FFT slave interface.

---
 rtl/wb_fft_slave_ctrl.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_wb_fft_slave_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_fft_slave_ctrl.sv
// -----------------------------------------------------------------------------
// wb_fft_slave_ctrl
//
// Wishbone B3 classic slave in front of the FFT core. The bus side streams
// input samples to the core, a small FSM sequences IDLE -> LOAD -> RUN -> DONE,
// and an N x DW result RAM (filled by the core) is readable through a bus
// window. Every access gets a registered ACK or ERR one cycle after the
// request is seen.
//
// Register map (byte offsets, only adr[LOG2N+2:0] decoded, adr[1:0] ignored):
//   REG_CTRL   : W bit0 CLEAR (pulse), bit1 irq_en ; R {0, irq_en, 0}
//   REG_DATA   : W sample push ; R 0
//   REG_STATUS : R bit0 done, bit1 ovf, [3:2] fsm code, [LOG2N+4:4] count
//   REG_MEM .. REG_MEM+4N-4 : R result RAM word, W accepted and ignored
//   anything else : ERR termination
//
// Handshake: a request is stb_i & cyc_i. It is accepted on a rising edge
// when no termination is currently being presented (ack_q|err_q low), and is
// terminated by a one-cycle ack_o/err_o pulse on the following cycle. Read
// data is valid only while ack_o is high; otherwise wb_dat_o is zero.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   wb_adr_i/dat_i/we_i/stb_i/cyc_i   Wishbone request
//   wb_dat_o/ack_o/err_o       Wishbone response
//   fft_sample_o/fft_sample_vld     sample to core, 1-cycle valid pulse
//   fft_clear_o                1-cycle pulse resetting the core
//   fft_done_i                 core finished (level; rising edge used)
//   fft_res_we_i/adr_i/dat_i   core write port into the result RAM
//   irq_o                      interrupt
//   dbg_state_o                current FSM state (for checkers)
//
// Configuration macro: WB_FFT_IRQ_EN
//   defined   : irq_o set on RUN->DONE when irq_en, held until CLEAR or irq_en=0
//   undefined : irq_o tied 0, CTRL bit1 reads 0 and writes are ignored
// -----------------------------------------------------------------------------
module wb_fft_slave_ctrl #(
  parameter int N          = 1024,
  parameter int LOG2N      = 10,
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int REG_CTRL   = 0,
  parameter int REG_DATA   = 4,
  parameter int REG_STATUS = 8,
  parameter int REG_MEM    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    wb_adr_i,
  input  logic [DW-1:0]    wb_dat_i,
  output logic [DW-1:0]    wb_dat_o,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic [DW-1:0]    fft_sample_o,
  output logic             fft_sample_vld,
  output logic             fft_clear_o,
  input  logic             fft_done_i,
  input  logic             fft_res_we_i,
  input  logic [LOG2N-1:0] fft_res_adr_i,
  input  logic [DW-1:0]    fft_res_dat_i,
  output logic             irq_o,
  output logic [1:0]       dbg_state_o
);

  // Decoded offset width in bytes, and the same offset in word units.
  localparam int OW = LOG2N + 3;
  localparam int WW = OW - 2;
  // Sample counter reaches N, so it needs one bit more than an index.
  localparam int CW = LOG2N + 1;

  localparam logic [WW-1:0] CTRL_W   = WW'(REG_CTRL / 4);
  localparam logic [WW-1:0] DATA_W   = WW'(REG_DATA / 4);
  localparam logic [WW-1:0] STATUS_W = WW'(REG_STATUS / 4);
  localparam logic [WW-1:0] MEM_LO_W = WW'(REG_MEM / 4);
  localparam logic [WW-1:0] MEM_HI_W = WW'((REG_MEM + 4 * N - 4) / 4);
  localparam logic [CW-1:0] N_C      = CW'(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            done_in_q, done_in_d;
  logic            irq_en_q, irq_en_d;
  logic            irq_q, irq_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            vld_q, vld_d;
  logic            clr_q, clr_d;
  logic [DW-1:0]   sample_q, sample_d;
  logic [DW-1:0]   rdat_q, rdat_d;
  logic            mem_sel_q, mem_sel_d;

  // Result RAM and its synchronous read register.
  logic [DW-1:0]   ram [N];
  logic [DW-1:0]   ram_q;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic            req;
  logic [WW-1:0]   word_adr;
  logic [WW-1:0]   mem_rel;
  logic [LOG2N-1:0] mem_idx;
  logic            hit_ctrl, hit_data, hit_status, hit_mem, hit_any;
  logic            done_rise;
  logic            mem_rd_en;
  logic [DW-1:0]   status_word;

  // Upper address bits and the byte lane bits take no part in decode.
  logic            unused_adr;
  assign unused_adr = ^{wb_adr_i[AW-1:OW], wb_adr_i[1:0], mem_rel[WW-1]};

  // A new request is held off while its termination is on the bus, so a
  // master that keeps stb high never sees two terminations back to back.
  assign req        = wb_stb_i & wb_cyc_i & ~(ack_q | err_q);
  assign word_adr   = wb_adr_i[OW-1:2];
  assign hit_ctrl   = (word_adr == CTRL_W);
  assign hit_data   = (word_adr == DATA_W);
  assign hit_status = (word_adr == STATUS_W);
  assign hit_mem    = (word_adr >= MEM_LO_W) && (word_adr <= MEM_HI_W);
  assign hit_any    = hit_ctrl | hit_data | hit_status | hit_mem;
  assign mem_rel    = word_adr - MEM_LO_W;
  assign mem_idx    = mem_rel[LOG2N-1:0];
  assign mem_rd_en  = req & hit_mem & ~wb_we_i;
  assign done_rise  = fft_done_i & ~done_in_q;

  always_comb begin
    status_word           = '0;
    status_word[0]        = (state_q == ST_DONE);
    status_word[1]        = ovf_q;
    status_word[3:2]      = state_q;
    status_word[CW+3:4]   = count_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    done_in_d = fft_done_i;
    irq_en_d  = irq_en_q;
    irq_d     = irq_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    vld_d     = 1'b0;
    clr_d     = 1'b0;
    sample_d  = sample_q;
    rdat_d    = '0;
    mem_sel_d = 1'b0;

    // Core completion only matters while running.
    if ((state_q == ST_RUN) && done_rise) begin
      state_d = ST_DONE;
    end

    if (req) begin
      if (!hit_any) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        if (wb_we_i) begin
          if (hit_ctrl) begin
`ifdef WB_FFT_IRQ_EN
            irq_en_d = wb_dat_i[1];
`endif
            // CLEAR is applied last among FSM updates so it also beats a
            // simultaneous done rise.
            if (wb_dat_i[0]) begin
              clr_d   = 1'b1;
              state_d = ST_IDLE;
              count_d = '0;
              ovf_d   = 1'b0;
            end
          end else if (hit_data) begin
            if ((state_q == ST_IDLE) || (state_q == ST_LOAD)) begin
              sample_d = wb_dat_i;
              vld_d    = 1'b1;
              count_d  = (count_q < N_C) ? count_q + 1'b1 : count_q;
              state_d  = (count_d == N_C) ? ST_RUN : ST_LOAD;
            end else begin
              // Frame already complete: drop the sample, remember it.
              ovf_d = 1'b1;
            end
          end
          // Writes to STATUS or the result window are acknowledged only.
        end else begin
          if (hit_ctrl) begin
            rdat_d[1] = irq_en_q;
          end else if (hit_status) begin
            rdat_d = status_word;
          end else if (hit_mem) begin
            mem_sel_d = 1'b1;
          end
          // DATA reads return zero.
        end
      end
    end

`ifdef WB_FFT_IRQ_EN
    if (clr_d || !irq_en_d) begin
      irq_d = 1'b0;
    end else if ((state_q == ST_RUN) && (state_d == ST_DONE)) begin
      irq_d = 1'b1;
    end
`else
    irq_en_d = 1'b0;
    irq_d    = 1'b0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Registers (FSM and all registered outputs)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      done_in_q <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      vld_q     <= 1'b0;
      clr_q     <= 1'b0;
      sample_q  <= '0;
      rdat_q    <= '0;
      mem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      done_in_q <= done_in_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      vld_q     <= vld_d;
      clr_q     <= clr_d;
      sample_q  <= sample_d;
      rdat_q    <= rdat_d;
      mem_sel_q <= mem_sel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Result RAM: core write port, bus synchronous read port. A read and a
  // write to the same word on the same edge return the previous contents.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (fft_res_we_i) begin
      ram[fft_res_adr_i] <= fft_res_dat_i;
    end
    if (mem_rd_en) begin
      ram_q <= ram[mem_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. rdat_q and mem_sel_q are single-cycle, so read data is zero
  // outside the acknowledging cycle.
  // ---------------------------------------------------------------------------
  assign wb_dat_o       = mem_sel_q ? ram_q : rdat_q;
  assign wb_ack_o       = ack_q;
  assign wb_err_o       = err_q;
  assign fft_sample_o   = sample_q;
  assign fft_sample_vld = vld_q;
  assign fft_clear_o    = clr_q;
  assign irq_o          = irq_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_wb_fft_slave_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_fft_slave_ctrl
//
// Directed bench for wb_fft_slave_ctrl, built with a small frame (N=16) so a
// full load/run/done sequence stays short. Expected values are written out by
// hand from the register map.
// -----------------------------------------------------------------------------
module tb_wb_fft_slave_ctrl;

  localparam int N     = 16;
  localparam int LOG2N = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;

  localparam logic [31:0] A_CTRL   = 32'd0;
  localparam logic [31:0] A_DATA   = 32'd4;
  localparam logic [31:0] A_STATUS = 32'd8;
  localparam logic [31:0] A_MEM    = 32'd12;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]    wb_adr_i = '0;
  logic [DW-1:0]    wb_dat_i = '0;
  logic [DW-1:0]    wb_dat_o;
  logic             wb_we_i = 1'b0;
  logic             wb_stb_i = 1'b0;
  logic             wb_cyc_i = 1'b0;
  logic             wb_ack_o;
  logic             wb_err_o;
  logic [DW-1:0]    fft_sample_o;
  logic             fft_sample_vld;
  logic             fft_clear_o;
  logic             fft_done_i = 1'b0;
  logic             fft_res_we_i = 1'b0;
  logic [LOG2N-1:0] fft_res_adr_i = '0;
  logic [DW-1:0]    fft_res_dat_i = '0;
  logic             irq_o;
  logic [1:0]       dbg_state_o;

  wb_fft_slave_ctrl #(.N(N), .LOG2N(LOG2N), .DW(DW), .AW(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wb_adr_i       (wb_adr_i),
    .wb_dat_i       (wb_dat_i),
    .wb_dat_o       (wb_dat_o),
    .wb_we_i        (wb_we_i),
    .wb_stb_i       (wb_stb_i),
    .wb_cyc_i       (wb_cyc_i),
    .wb_ack_o       (wb_ack_o),
    .wb_err_o       (wb_err_o),
    .fft_sample_o   (fft_sample_o),
    .fft_sample_vld (fft_sample_vld),
    .fft_clear_o    (fft_clear_o),
    .fft_done_i     (fft_done_i),
    .fft_res_we_i   (fft_res_we_i),
    .fft_res_adr_i  (fft_res_adr_i),
    .fft_res_dat_i  (fft_res_dat_i),
    .irq_o          (irq_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and pulse monitors
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int vld_cnt  = 0;
  int clr_cnt  = 0;

  always @(negedge clk) begin
    if (fft_sample_vld === 1'b1) vld_cnt++;
    if (fft_clear_o === 1'b1) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  logic [31:0] last_rdat;
  logic        last_ack;
  logic        last_err;
  logic        last_vld;
  logic [31:0] last_smp;
  int          last_lat;

  task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    bit got;
    @(posedge clk); #1;
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    got = 1'b0;
    last_ack = 1'b0; last_err = 1'b0; last_vld = 1'b0;
    last_rdat = '0; last_smp = '0; last_lat = 0;
    for (int i = 1; i <= 8; i++) begin
      if (!got) begin
        @(posedge clk); #1;
        if (wb_ack_o === 1'b1 || wb_err_o === 1'b1) begin
          got = 1'b1;
          last_ack = wb_ack_o; last_err = wb_err_o;
          last_rdat = wb_dat_o; last_vld = fft_sample_vld;
          last_smp = fft_sample_o; last_lat = i;
        end
      end
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $error("FAIL timeout observed=no_termination expected=ack_or_err adr=0x%0h", adr);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_xfer(adr, 1'b1, dat);
  endtask

  task automatic wb_read(input logic [31:0] adr);
    wb_xfer(adr, 1'b0, '0);
  endtask

  task automatic core_write(input int k, input logic [31:0] d);
    @(posedge clk); #1;
    fft_res_we_i = 1'b1; fft_res_adr_i = LOG2N'(k); fft_res_dat_i = d;
    @(posedge clk); #1;
    fft_res_we_i = 1'b0;
  endtask

  task automatic load_frame();
    for (int i = 0; i < N; i++) wb_write(A_DATA, 32'(i));
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int vld_before;
  int clr_before;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctl_outs", {27'd0, wb_ack_o, wb_err_o, fft_sample_vld, fft_clear_o, irq_o}, 32'h0);
    check("rst_dat_o", wb_dat_o, 32'h0);
    check("rst_sample_o", fft_sample_o, 32'h0);
    rst_n = 1'b1;
    wb_read(A_STATUS);
    check("status_after_reset", last_rdat, 32'h0);
    check("status_ack_lat", 32'(last_lat), 32'd1);

    // Reset in the middle of LOAD with count=5
    for (int i = 0; i < 5; i++) wb_write(A_DATA, 32'hA0 + 32'(i));
    check("sample_o_5th", last_smp, 32'hA4);
    check("vld_with_ack", {31'd0, last_vld}, 32'd1);
    wb_read(A_STATUS);
    check("status_load5", last_rdat, 32'h54);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midload_rst_outs", {27'd0, wb_ack_o, wb_err_o, fft_sample_vld, fft_clear_o, irq_o}, 32'h0);
    check("midload_rst_smp", fft_sample_o, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_read(A_STATUS);
    check("status_after_midload_rst", last_rdat, 32'h0);

    // CLEAR then a full frame
    clr_before = clr_cnt;
    wb_write(A_CTRL, 32'h1);
    @(posedge clk); #1;
    check("clear_one_pulse", 32'(clr_cnt - clr_before), 32'd1);
    vld_before = vld_cnt;
    load_frame();
    @(posedge clk); #1;
    check("frame_vld_pulses", 32'(vld_cnt - vld_before), 32'(N));
    check("frame_last_sample", last_smp, 32'(N - 1));
    wb_read(A_STATUS);
    check("status_run", last_rdat, 32'h108);

    // Core fills the result RAM and signals completion
    for (int k = 0; k < N; k++) core_write(k, 32'(3 * k));
    fft_done_i = 1'b1;
    wb_read(A_STATUS);
    check("status_done", last_rdat, 32'h10D);

    // Result window reads
    wb_read(A_MEM);
    check("mem_k0", last_rdat, 32'd0);
    check("mem_k0_lat", 32'(last_lat), 32'd1);
    wb_read(A_MEM + 32'(4 * (N - 1)));
    check("mem_kN_1", last_rdat, 32'd45);
    check("mem_kN_1_ack", {31'd0, last_ack}, 32'd1);
    wb_read(A_MEM + 32'd28);
    check("mem_k7", last_rdat, 32'd21);
    @(posedge clk); #1;
    check("dat_o_idle_zero", wb_dat_o, 32'h0);

    // Same-word core write and bus read on one edge returns old data
    @(posedge clk); #1;
    wb_adr_i = A_MEM + 32'd16; wb_we_i = 1'b0;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    fft_res_we_i = 1'b1; fft_res_adr_i = 4'd4; fft_res_dat_i = 32'hDEAD;
    @(posedge clk); #1;
    fft_res_we_i = 1'b0;
    check("collide_ack", {31'd0, wb_ack_o}, 32'd1);
    check("collide_old", wb_dat_o, 32'd12);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    wb_read(A_MEM + 32'd16);
    check("collide_new", last_rdat, 32'hDEAD);

    // DATA write while DONE: acked, dropped, overflow flagged
    vld_before = vld_cnt;
    wb_write(A_DATA, 32'h55);
    check("ovf_wr_ack", {30'd0, last_ack, last_err}, 32'd2);
    @(posedge clk); #1;
    check("ovf_no_vld", 32'(vld_cnt - vld_before), 32'd0);
    wb_read(A_STATUS);
    check("status_ovf", last_rdat, 32'h10F);

    // DATA read is zero; result window write is ignored
    wb_read(A_DATA);
    check("data_read_zero", last_rdat, 32'h0);
    wb_write(A_MEM + 32'd4, 32'hFFFF);
    check("mem_wr_ack", {30'd0, last_ack, last_err}, 32'd2);
    wb_read(A_MEM + 32'd4);
    check("mem_wr_ignored", last_rdat, 32'd3);

    // CLEAR returns everything to zero with a single clear pulse
    clr_before = clr_cnt;
    wb_write(A_CTRL, 32'h1);
    wb_read(A_STATUS);
    check("status_cleared", last_rdat, 32'h0);
    check("clear_pulse2", 32'(clr_cnt - clr_before), 32'd1);

    // Unmapped addresses
    wb_read(A_MEM + 32'(4 * N));
    check("err_past_window", {30'd0, last_ack, last_err}, 32'd1);
    check("err_lat", 32'(last_lat), 32'd1);
    @(posedge clk); #1;
    check("err_one_cycle", {31'd0, wb_err_o}, 32'd0);
    wb_write(32'h1000_0000 | (A_MEM + 32'(4 * N)), 32'h1);
    check("err_high_adr", {30'd0, last_ack, last_err}, 32'd1);
    wb_read(32'd124);
    check("err_top", {30'd0, last_ack, last_err}, 32'd1);

    // Strobe held high: terminations never on consecutive cycles
    @(posedge clk); #1;
    wb_adr_i = A_STATUS; wb_we_i = 1'b0;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    @(posedge clk); #1;
    check("b2b_ack1", {31'd0, wb_ack_o}, 32'd1);
    @(posedge clk); #1;
    check("b2b_gap", {31'd0, wb_ack_o}, 32'd0);
    @(posedge clk); #1;
    check("b2b_ack2", {31'd0, wb_ack_o}, 32'd1);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    @(posedge clk); #1;
    check("b2b_end", {31'd0, wb_ack_o}, 32'd0);

    // Done rising in IDLE and LOAD is ignored
    fft_done_i = 1'b0;
    @(posedge clk); #1;
    fft_done_i = 1'b1;
    wb_read(A_STATUS);
    check("done_in_idle", last_rdat, 32'h0);
    fft_done_i = 1'b0;
    wb_write(A_DATA, 32'h7);
    fft_done_i = 1'b1;
    wb_read(A_STATUS);
    check("done_in_load", last_rdat, 32'h14);
    fft_done_i = 1'b0;
    wb_write(A_CTRL, 32'h1);

    // CLEAR on the same edge as a done rise: CLEAR wins
    load_frame();
    @(posedge clk); #1;
    wb_adr_i = A_CTRL; wb_we_i = 1'b1; wb_dat_i = 32'h1;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    fft_done_i = 1'b1;
    @(posedge clk); #1;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    wb_read(A_STATUS);
    check("clear_beats_done", last_rdat, 32'h0);
    fft_done_i = 1'b0;

    // Interrupt
    wb_write(A_CTRL, 32'h2);
    wb_read(A_CTRL);
`ifdef WB_FFT_IRQ_EN
    check("ctrl_irq_en_rd", last_rdat, 32'h2);
    load_frame();
    check("irq_low_in_run", {31'd0, irq_o}, 32'd0);
    fft_done_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("irq_on_done", {31'd0, irq_o}, 32'd1);
    wb_write(A_CTRL, 32'h1);
    @(posedge clk); #1;
    check("irq_cleared", {31'd0, irq_o}, 32'd0);
`else
    check("ctrl_irq_en_rd", last_rdat, 32'h0);
    load_frame();
    fft_done_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("irq_tied_low", {31'd0, irq_o}, 32'd0);
    wb_read(A_STATUS);
    check("status_done2", last_rdat, 32'h10D);
    wb_write(A_CTRL, 32'h1);
`endif
    fft_done_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
